// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg: shared types, default sizes and index helper for pipe_share_arb
// Contents: arbiter state enum, default parameter values, derived widths,
//           modular "next index" helper used to seed the round-robin search.
package pipe_share_pkg;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   localparam int N_DFLT         = 4;
   localparam int W_DFLT         = 4;
   localparam int MAX_BURST_DFLT = 2;
   localparam int ID_W           = $clog2(N_DFLT);
   localparam int CNT_W          = $clog2(MAX_BURST_DFLT + 1);

   // Index following idx in a ring of n entries.
   function automatic int next_idx(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pipe_share_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker
// Ports:
//   req_i   in  N   request vector
//   start_i in  IW  index with highest priority
//   found_o out 1   at least one request present
//   idx_o   out IW  first requesting index at or after start_i (mod N)
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   localparam int SW = IW + 1;
   localparam logic [SW-1:0] NV = SW'(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IW-1:0]  off;
   logic [SW-1:0]  sum;

   // Rotating a doubled copy puts the start index at bit 0, so the
   // lowest set bit is the distance from start to the winner.
   assign dbl = {req_i, req_i};
   assign rot = N'(dbl >> start_i);

   always_comb begin
      off = '0;
      for (int k = N - 1; k >= 0; k--)
         if (rot[k]) off = IW'(k);
      sum     = {1'b0, start_i} + {1'b0, off};
      idx_o   = (sum >= NV) ? IW'(sum - NV) : sum[IW-1:0];
      found_o = |req_i;
   end

endmodule

// File: rtl/pipe_share_arb.sv
// pipe_share_arb: round-robin arbiter with burst lock sharing one push-only pipeline
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en_i          arbitration enable
//   req_valid_i   per-requester valid (N)
//   req_data_i    per-requester data, requester i at [i*W +: W]
//   req_ready_o   per-requester grant, combinational, one-hot or zero
//   dp_valid_o    registered valid to the pipeline
//   dp_data_o     registered data to the pipeline
//   dp_id_o       registered ID of the requester served
//   busy_o        high while a burst is in progress
module pipe_share_arb
   import pipe_share_pkg::*;
#(
   parameter int N         = N_DFLT,
   parameter int W         = W_DFLT,
   parameter int MAX_BURST = MAX_BURST_DFLT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [N-1:0]         req_valid_i,
   input  logic [N*W-1:0]       req_data_i,
   output logic [N-1:0]         req_ready_o,
   output logic                 dp_valid_o,
   output logic [W-1:0]         dp_data_o,
   output logic [$clog2(N)-1:0] dp_id_o,
   output logic                 busy_o
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_t         state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           dp_valid_q;
   logic [W-1:0]   dp_data_q;
   logic [IW-1:0]  dp_id_q;

   logic [W-1:0]   data_arr [N];
   logic [IW-1:0]  start;
   logic           found;
   logic [IW-1:0]  pick;
   logic           hold;
   logic           grant;
   logic [IW-1:0]  winner;

   for (genvar g = 0; g < N; g++) begin : g_split
      assign data_arr[g] = req_data_i[g*W +: W];
   end

   // The search always begins one past the last owner, even from IDLE,
   // so a reset owner of N-1 makes requester 0 the first candidate.
   assign start = IW'(next_idx(int'(owner_q), N));

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req_i   (req_valid_i),
      .start_i (start),
      .found_o (found),
      .idx_o   (pick)
   );

   assign hold   = (state_q == BURST) && en_i && req_valid_i[owner_q] && (cnt_q < CW'(MAX_BURST));
   assign grant  = !rst && (hold || (en_i && found));
   assign winner = hold ? owner_q : pick;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= IW'(N - 1);
         cnt_q      <= '0;
         dp_valid_q <= 1'b0;
         dp_data_q  <= '0;
         dp_id_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         dp_valid_q <= grant;
         dp_data_q  <= grant ? data_arr[winner] : dp_data_q;
         dp_id_q    <= grant ? winner : dp_id_q;
      end
   end

   always_comb begin
      state_d = grant ? BURST : IDLE;
      owner_d = grant ? winner : owner_q;
      cnt_d   = hold ? cnt_q + CW'(1) : (grant ? CW'(1) : '0);
   end

   always_comb begin
      req_ready_o = grant ? (N'(1) << winner) : '0;
      busy_o      = !rst && (state_q == BURST);
      dp_valid_o  = dp_valid_q;
      dp_data_o   = dp_data_q;
      dp_id_o     = dp_id_q;
   end

   assert property (@(posedge clk) $onehot0(req_ready_o));

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb_pipe_share_arb: directed scenarios plus random traffic against a rule-level model
module tb_pipe_share_arb;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int MB = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en_i = 1'b1;
   logic [N-1:0]   req_valid_i = '0;
   logic [N*W-1:0] req_data_i = '0;
   logic [N-1:0]   req_ready_o;
   logic           dp_valid_o;
   logic [W-1:0]   dp_data_o;
   logic [1:0]     dp_id_o;
   logic           busy_o;

   int n_asrt = 0;
   int n_fail = 0;

   int m_owner = N - 1;
   int m_cnt   = 0;
   bit m_burst = 1'b0;
   bit m_dv    = 1'b0;
   int m_dd    = 0;
   int m_did   = 0;

   logic [N-1:0] seen_rdy;
   logic         seen_dv;
   logic [W-1:0] seen_dd;
   logic [1:0]   seen_id;
   logic         seen_busy;

   int t3 [8] = '{1, 1, 4, 4, 1, 1, 4, 4};

   pipe_share_arb #(.N(N), .W(W), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .dp_valid_o  (dp_valid_o),
      .dp_data_o   (dp_data_o),
      .dp_id_o     (dp_id_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hold();
      return !rst && en_i && m_burst && req_valid_i[m_owner] && (m_cnt < MB);
   endfunction

   // Winner under the arbitration rules, or -1 when nobody is served.
   function automatic int model_pick();
      if (rst || !en_i) return -1;
      if (model_hold()) return m_owner;
      for (int k = 1; k <= N; k++)
         if (req_valid_i[(m_owner + k) % N]) return (m_owner + k) % N;
      return -1;
   endfunction

   task automatic cyc();
      int g;
      bit h;
      @(negedge clk);
      g = model_pick();
      h = model_hold();
      chk("ready", 32'(req_ready_o), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("dp_valid", 32'(dp_valid_o), 32'(m_dv));
      chk("dp_data", 32'(dp_data_o), 32'(m_dd));
      chk("dp_id", 32'(dp_id_o), 32'(m_did));
      chk("busy", 32'(busy_o), 32'(!rst && m_burst));
      seen_rdy  = req_ready_o;
      seen_dv   = dp_valid_o;
      seen_dd   = dp_data_o;
      seen_id   = dp_id_o;
      seen_busy = busy_o;
      @(posedge clk);
      if (rst) begin
         m_owner = N - 1;
         m_cnt   = 0;
         m_burst = 1'b0;
         m_dv    = 1'b0;
         m_dd    = 0;
         m_did   = 0;
      end else begin
         m_cnt   = h ? m_cnt + 1 : ((g >= 0) ? 1 : 0);
         m_burst = (g >= 0);
         m_dv    = (g >= 0);
         if (g >= 0) begin
            m_owner = g;
            m_did   = g;
            m_dd    = 32'((req_data_i >> (g * W)) & 16'hF);
         end
      end
      #1;
   endtask

   initial begin
      // Reset with every requester asking
      rst = 1'b1;
      en_i = 1'b1;
      req_valid_i = 4'b1111;
      req_data_i = 16'($urandom);
      repeat (2) begin
         cyc();
         chk("rst_ready", 32'(seen_rdy), 32'd0);
         chk("rst_dv", 32'(seen_dv), 32'd0);
         chk("rst_busy", 32'(seen_busy), 32'd0);
      end
      rst = 1'b0;
      // Lone requester streams through the burst boundary
      req_valid_i = 4'b0010;
      for (int d = 1; d <= 4; d++) begin
         req_data_i[7:4] = 4'(d);
         cyc();
         chk("t2_ready", 32'(seen_rdy), 32'h2);
         if (d > 1) begin
            chk("t2_data", 32'(seen_dd), 32'(d - 1));
            chk("t2_id", 32'(seen_id), 32'd1);
         end
      end
      req_valid_i = 4'b0000;
      cyc();
      chk("t2_last_data", 32'(seen_dd), 32'd4);
      chk("t2_last_dv", 32'(seen_dv), 32'd1);
      // Two-way burst rotation from a fresh reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      req_valid_i = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("t3_ready", 32'(seen_rdy), 32'(t3[i]));
         if (i > 0) begin
            chk("t3_dv", 32'(seen_dv), 32'd1);
            chk("t3_id", 32'(seen_id), (t3[i-1] == 1) ? 32'd0 : 32'd2);
         end
      end
      // Owner drop re-arbitrates without a bubble
      req_valid_i = 4'b1000;
      cyc();
      chk("t4_ready3", 32'(seen_rdy), 32'h8);
      req_valid_i = 4'b0001;
      cyc();
      chk("t4_ready0", 32'(seen_rdy), 32'h1);
      chk("t4_id3", 32'(seen_id), 32'd3);
      req_valid_i = 4'b0000;
      cyc();
      chk("t4_id0", 32'(seen_id), 32'd0);
      chk("t4_dv", 32'(seen_dv), 32'd1);
      // Enable pause keeps the round-robin position
      req_valid_i = 4'b1111;
      cyc();
      chk("t5_ready1", 32'(seen_rdy), 32'h2);
      en_i = 1'b0;
      for (int p = 0; p < 3; p++) begin
         cyc();
         chk("t5_pause_ready", 32'(seen_rdy), 32'd0);
         if (p > 0) chk("t5_pause_dv", 32'(seen_dv), 32'd0);
      end
      en_i = 1'b1;
      cyc();
      chk("t5_resume", 32'(seen_rdy), 32'h4);
      // Reset in the middle of req2's burst
      rst = 1'b1;
      req_valid_i = 4'b0101;
      cyc();
      chk("t6_rst_ready", 32'(seen_rdy), 32'd0);
      chk("t6_rst_busy", 32'(seen_busy), 32'd0);
      rst = 1'b0;
      cyc();
      chk("t6_no_beat", 32'(seen_dv), 32'd0);
      chk("t6_first", 32'(seen_rdy), 32'h1);
      // Random traffic; a requester keeps valid and data until granted
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 49) == 0);
         en_i = ($urandom_range(0, 7) != 0);
         for (int r = 0; r < N; r++)
            if (!req_valid_i[r] || seen_rdy[r]) begin
               req_valid_i[r] = ($urandom_range(0, 2) != 0);
               req_data_i[r*W +: W] = 4'($urandom);
            end
         cyc();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
- Shares one valid/data accumulate pipeline between N requesters.
- Picks one requester per cycle with round-robin priority, with an optional burst lock.
- Drives the pipeline's valid/data inputs from a register, together with the ID of the requester served.
- Sits between the requester interfaces and the pipeline. The pipeline has no backpressure, so the arbiter's output is push-only.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, data width per requester.
- MAX_BURST, 2, most consecutive beats one requester may take before rotating (1 = strict per-beat round-robin).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_i  in  1  arbitration enable; when low, no grants are issued
- req_valid_i  in  N  per-requester valid
- req_data_i  in  N*W  per-requester data; requester i uses bits [i*W +: W]
- req_ready_o  out  N  per-requester grant/ready (combinational, one-hot or zero)
- dp_valid_o  out  1  registered valid to the pipeline
- dp_data_o  out  W  registered data to the pipeline
- dp_id_o  out  clog2(N)  registered ID of the requester served
- busy_o  out  1  high while state is BURST

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. Every register is reset, including the data registers.
- Reset values: dp_valid_o=0, dp_data_o=0, dp_id_o=0, owner=N-1, cnt=0, state=IDLE.
  - busy_o=0 and req_ready_o=0 during reset, regardless of req_valid_i.
- Handshake: a beat transfers when req_valid_i[i] && req_ready_o[i].
  - A requester holds valid and data stable until it is granted.
  - req_ready_o never depends on req_ready_o itself and has no combinational path to dp_*.
- Latency: 1 cycle. A beat accepted in cycle t appears on dp_valid_o/dp_data_o/dp_id_o in cycle t+1.
  - dp_valid_o=0 in any cycle after no grant. dp_data_o and dp_id_o hold their previous values then.
- FSM states:
  - IDLE: no grant last cycle.
  - BURST: a grant to `owner` last cycle, with cnt beats taken consecutively.
- Hold condition: state==BURST && en_i && req_valid_i[owner] && cnt<MAX_BURST.
  - If hold is true: grant owner, cnt<=cnt+1, stay in BURST.
- Otherwise, search:
  - Grant the first valid requester in the order owner+1, owner+2, ..., owner (mod N). The search starts at owner+1 even from IDLE.
  - On a grant: owner<=winner, cnt<=1, state<=BURST.
  - With no valid requester, or en_i=0: no grant, state<=IDLE, owner unchanged, cnt<=0.
- Rotation when the burst is exhausted or the owner drops valid:
  - Re-arbitration happens in the same cycle, with no bubble.
  - If the owner is the only valid requester, it wins the search again with cnt=1. A lone requester therefore streams continuously.
- en_i low:
  - req_ready_o=0 and state<=IDLE.
  - owner is kept, so round-robin fairness resumes from the same point.
- MAX_BURST=1: the hold condition is never true; the block is a pure per-beat round-robin arbiter.
- Mid-burst reset: the burst is abandoned with no output beat in the reset cycle. The next grant searches from requester 0.
- cnt width: clog2(MAX_BURST+1). cnt saturates by construction, since cnt<MAX_BURST gates the increment.
- At most one bit of req_ready_o is high per cycle (checked by assertion).

Decomposition:
- Package pipe_share_pkg:
  - state enum {IDLE, BURST}
  - localparams ID_W=clog2(N) and CNT_W=clog2(MAX_BURST+1)
- One sub-module, rr_pick:
  - Purely combinational rotating-priority picker.
  - Inputs: N-bit request vector, start index.
  - Outputs: found flag and winner index.
  - Instantiated once for the search path.

Test Plan:
1. Reset check: assert rst for 2 cycles while req_valid_i=4'b1111.
   - Expect req_ready_o=0, dp_valid_o=0, dp_data_o=0, dp_id_o=0, busy_o=0 throughout.
2. Lone requester, N=4, MAX_BURST=2: req1 valid constantly with data 1,2,3,4.
   - Expect grants every cycle.
   - Expect dp_id_o=1 and dp_data_o=1,2,3,4, each delayed one cycle.
   - Expect no gap at the burst boundary.
3. Two-way burst rotation: req0 and req2 held valid constantly.
   - Expect grant sequence 0,0,2,2,0,0,2,2.
   - Expect dp_id_o to follow one cycle later with no idle cycles.
4. Owner drop: req3 granted with cnt=1, then req3 deasserts while req0 is valid.
   - Expect req0 granted in the same cycle.
   - Expect dp_id_o sequence 3 then 0.
5. en_i pause: all four requesters valid, en_i=0 for 3 cycles, then en_i=1 after a grant to req1.
   - Expect no ready and dp_valid_o=0 during the pause.
   - Expect the first grant after the pause to go to req2.
6. Reset mid-burst: rst pulsed while req2 is owner with cnt=1, req2 and req0 valid.
   - Expect no beat in the reset cycle.
   - Expect req0 granted first after reset.
